// File: rtl/tof_pkg.sv
// tof_pkg: shared encodings for the ToF command sequencer.
// Covers ToF FSM status codes, response codes and sequencer states.
package tof_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RELEASE, ST_RESP} state_e;
    localparam logic [1:0] STS_IDLE = 2'b00;
    localparam logic [1:0] STS_BUSY = 2'b01;
    localparam logic [1:0] STS_ACK  = 2'b10;
    localparam logic [1:0] STS_ERR  = 2'b11;
    localparam logic [1:0] RSP_OK         = 2'b00;
    localparam logic [1:0] RSP_SENSOR_ERR = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT    = 2'b10;
    localparam logic [1:0] RSP_ILLEGAL    = 2'b11;
    localparam int REQ_W = 7;
endpackage

// File: rtl/tof_cmd_fifo.sv
// tof_cmd_fifo: request queue, first-word fall-through read, pushes ignored while full.
// empty_nxt exposes the next-cycle empty flag so the parent can register busy.
module tof_cmd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic full_q, full_d, empty_q, empty_d, do_push, do_pop;
    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        full_d  = cnt_d == CW'(DEPTH);
        empty_d = cnt_d == '0;
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
    assign dout      = mem_q[rd_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;
endmodule

// File: rtl/tof_cmd_sequencer.sv
// tof_cmd_sequencer: drains queued {sensor, cmd} requests into per-sensor nibbles
// and runs the drive/ACK/release handshake against the ToF FSM status bits.
module tof_cmd_sequencer
    import tof_pkg::*;
#(
    parameter int NUM_SENSORS = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 50000,
    parameter int TMO_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_sensor,
    input  logic [3:0]               req_cmd,
    output logic [NUM_SENSORS*4-1:0] cmd_o,
    input  logic [NUM_SENSORS*2-1:0] status_i,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_sensor,
    output logic [1:0]               rsp_code,
    output logic                     busy
);
    state_e state_q, state_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [NUM_SENSORS*4-1:0] cmd_q, cmd_d;
    logic [2:0] sens_q, sens_d;
    logic [1:0] code_q, code_d, st;
    logic rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic pop, illegal, tmo_hit;
    logic [REQ_W-1:0] f_dout;
    logic f_full, f_empty, f_empty_nxt;
    tof_cmd_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .pop       (pop),
        .din       ({req_sensor, req_cmd}),
        .dout      (f_dout),
        .full      (f_full),
        .empty     (f_empty),
        .empty_nxt (f_empty_nxt)
    );
    // Only the status pair of the sensor currently being served matters.
    assign st      = status_i[{sens_q, 1'b0} +: 2];
    assign illegal = (32'(f_dout[6:4]) >= NUM_SENSORS) || (f_dout[3:0] == 4'h0);
    assign tmo_hit = timer_q == TMO_W'(TIMEOUT - 1);
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_d       = cmd_q;
        sens_d      = sens_q;
        code_d      = code_q;
        rsp_valid_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!f_empty) begin
                    pop     = 1'b1;
                    sens_d  = f_dout[6:4];
                    timer_d = '0;
                    if (illegal) begin
                        code_d      = RSP_ILLEGAL;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        cmd_d = '0;
                        cmd_d[{f_dout[6:4], 2'b00} +: 4] = f_dout[3:0];
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (st == STS_ACK) begin
                    cmd_d   = '0;
                    timer_d = '0;
                    state_d = ST_RELEASE;
                end else if (st == STS_ERR || tmo_hit) begin
                    cmd_d       = '0;
                    code_d      = (st == STS_ERR) ? RSP_SENSOR_ERR : RSP_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (st != STS_ACK || tmo_hit) begin
                    code_d      = (st != STS_ACK) ? RSP_OK : RSP_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || !f_empty_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cmd_q       <= '0;
            sens_q      <= '0;
            code_q      <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            sens_q      <= sens_d;
            code_q      <= code_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end
    assign req_ready  = !f_full;
    assign cmd_o      = cmd_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_sensor = sens_q;
    assign rsp_code   = code_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_tof_cmd_sequencer.sv
// tb_tof_cmd_sequencer: vector table plus hand sequences for queueing and reset.
// A negedge responder emulates the ToF FSM status bits for each sensor.
module tb_tof_cmd_sequencer;
    import tof_pkg::*;
    localparam int NS  = 8;
    localparam int TMO = 16;
    localparam logic [1:0] K_NONE = 2'b00;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [2:0] req_sensor = '0;
    logic [3:0] req_cmd = '0;
    logic [31:0] cmd_o;
    logic [15:0] status = '0;
    logic rsp_valid;
    logic [2:0] rsp_sensor;
    logic [1:0] rsp_code;
    logic busy;
    int checks = 0;
    int failures = 0;
    int multi = 0;
    logic [1:0] kind [NS];
    int dly [NS];
    int hi [NS];
    int last_hi [NS];
    int rel [NS];
    logic [4:0] rsp_q [$];
    typedef struct {
        logic [2:0] s;
        logic [3:0] c;
        logic [1:0] k;
        int         d;
        logic [1:0] code;
        int         high;
    } vec_t;
    vec_t vecs [8];

    tof_cmd_sequencer #(.NUM_SENSORS(NS), .FIFO_DEPTH(4), .TIMEOUT(TMO), .TMO_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sensor (req_sensor),
        .req_cmd    (req_cmd),
        .cmd_o      (cmd_o),
        .status_i   (status),
        .rsp_valid  (rsp_valid),
        .rsp_sensor (rsp_sensor),
        .rsp_code   (rsp_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Raise the configured status once a nibble has been high for dly samples;
    // ACK is held two more cycles after the nibble drops, ERROR clears at once.
    always @(negedge clk) begin
        int nz;
        nz = 0;
        for (int s = 0; s < NS; s++) begin
            if (cmd_o[4*s +: 4] != 4'h0) begin
                nz++;
                hi[s]++;
                rel[s] = 0;
                if (hi[s] == dly[s] && kind[s] != K_NONE) status[2*s +: 2] = kind[s];
            end else begin
                if (hi[s] != 0) last_hi[s] = hi[s];
                hi[s] = 0;
                if (status[2*s +: 2] == STS_ERR) status[2*s +: 2] = 2'b00;
                else if (status[2*s +: 2] == STS_ACK) begin
                    rel[s]++;
                    if (rel[s] == 2) begin
                        status[2*s +: 2] = 2'b00;
                        rel[s] = 0;
                    end
                end
            end
        end
        if (nz > 1) multi++;
        if (rsp_valid) rsp_q.push_back({rsp_sensor, rsp_code});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [3:0] c);
        req_sensor = s;
        req_cmd    = c;
        req_valid  = 1'b1;
        @(negedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic arm(input int s, input logic [1:0] k, input int d);
        kind[s]    = k;
        dly[s]     = d;
        last_hi[s] = 0;
    endtask

    task automatic get_rsp(output logic [4:0] r);
        int n;
        n = 0;
        while (rsp_q.size() == 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rsp_q.size() == 0) begin
            chk("rsp_wait", 32'd0, 32'd1);
            r = '1;
        end else begin
            r = rsp_q.pop_front();
        end
    endtask

    initial begin
        logic [4:0] r;
        logic rdy [6];
        int n;
        for (int s = 0; s < NS; s++) begin
            kind[s] = K_NONE;
            dly[s] = 0;
            hi[s] = 0;
            last_hi[s] = 0;
            rel[s] = 0;
        end
        vecs[0] = '{3'd0, 4'h1, STS_ACK, 3,  RSP_OK,         3};
        vecs[1] = '{3'd5, 4'h2, STS_ERR, 4,  RSP_SENSOR_ERR, 4};
        vecs[2] = '{3'd6, 4'h9, K_NONE,  0,  RSP_TIMEOUT,    TMO};
        vecs[3] = '{3'd2, 4'h0, K_NONE,  0,  RSP_ILLEGAL,    0};
        vecs[4] = '{3'd3, 4'h1, STS_ACK, 1,  RSP_OK,         1};
        vecs[5] = '{3'd7, 4'hF, STS_ERR, 1,  RSP_SENSOR_ERR, 1};
        vecs[6] = '{3'd1, 4'h7, STS_ACK, 16, RSP_OK,         TMO};
        vecs[7] = '{3'd4, 4'h7, STS_ACK, 17, RSP_TIMEOUT,    TMO};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_o", cmd_o, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_sensor", 32'(rsp_sensor), 32'h0);
        chk("rst_rsp_code", 32'(rsp_code), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            arm(vecs[i].s, vecs[i].k, vecs[i].d);
            push(vecs[i].s, vecs[i].c);
            get_rsp(r);
            chk($sformatf("v%0d_sensor", i), 32'(r[4:2]), 32'(vecs[i].s));
            chk($sformatf("v%0d_code", i), 32'(r[1:0]), 32'(vecs[i].code));
            chk($sformatf("v%0d_nib_high", i), last_hi[vecs[i].s], vecs[i].high);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 32'h0);
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'h0);
            arm(vecs[i].s, K_NONE, 0);
        end

        arm(2, K_NONE, 0);
        arm(3, STS_ACK, 2);
        push(3'd2, 4'h0);
        push(3'd3, 4'h1);
        get_rsp(r);
        chk("ill_seq_first", 32'(r), 32'({3'd2, RSP_ILLEGAL}));
        get_rsp(r);
        chk("ill_seq_second", 32'(r), 32'({3'd3, RSP_OK}));
        chk("ill_seq_s2_high", last_hi[2], 0);
        chk("ill_seq_s3_high", last_hi[3], 2);
        arm(3, K_NONE, 0);
        repeat (3) @(negedge clk);
        #1;

        arm(0, K_NONE, 0);
        for (int s = 1; s <= 5; s++) arm(s, STS_ERR, 1);
        push(3'd0, 4'h1);
        n = 0;
        while (cmd_o[3:0] == 4'h0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("q_s0_driven", 32'(cmd_o), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            push(3'(i), 4'h2);
            rdy[i] = req_ready;
        end
        chk("q_ready_after_3", 32'(rdy[3]), 32'h1);
        chk("q_ready_after_4", 32'(rdy[4]), 32'h0);
        chk("q_ready_after_5", 32'(rdy[5]), 32'h0);
        for (int i = 0; i <= 4; i++) begin
            get_rsp(r);
            chk($sformatf("q_rsp%0d", i), 32'(r),
                32'({3'(i), (i == 0) ? RSP_TIMEOUT : RSP_SENSOR_ERR}));
        end
        chk("q_s0_high", last_hi[0], TMO);
        repeat (30) @(negedge clk);
        #1;
        chk("q_fifth_dropped", rsp_q.size(), 0);
        chk("q_busy_end", 32'(busy), 32'h0);
        chk("q_ready_end", 32'(req_ready), 32'h1);
        for (int s = 0; s <= 5; s++) arm(s, K_NONE, 0);

        arm(4, K_NONE, 0);
        push(3'd4, 4'h3);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_rst_pre_nib", 32'(cmd_o), 32'h0003_0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_o", cmd_o, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("mid_rst_no_rsp", rsp_q.size(), 0);
        chk("mid_rst_busy_after", 32'(busy), 32'h0);
        chk("one_hot_nibble", multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
